// File: rtl/cdb_arbiter_pkg.sv
// Shared completion-bus types: EX_IC_PACKET, FU count and FU index names.
// Used by the CDB arbiter and its request picker.
package cdb_arbiter_pkg;

    localparam int FU_COUNT  = 4;
    localparam int XLEN      = 32;
    localparam int TAG_W     = 6;
    localparam int ROB_IDX_W = 5;

    typedef enum logic [1:0] {
        FU_ALU  = 2'd0,
        FU_MULT = 2'd1,
        FU_LOAD = 2'd2,
        FU_BR   = 2'd3
    } fu_idx_e;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W-1:0]     dest_tag;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [XLEN-1:0]      result;
        logic [XLEN-1:0]      rs2_value;
        logic                 take_branch;
    } EX_IC_PACKET;

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational grant picker: round-robin from ptr, or fixed
// lowest-index priority when CDB_ARB_FIXED_PRIO_EN is defined.
module cdb_arbiter_rr_picker
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU   = FU_COUNT,
    parameter int FU_IDX_W = $clog2(NUM_FU)
) (
    input  logic [NUM_FU-1:0]   req,
    input  logic [FU_IDX_W-1:0] ptr,
    output logic [NUM_FU-1:0]   gnt,
    output logic [FU_IDX_W-1:0] idx,
    output logic                any
);

    logic [FU_IDX_W-1:0] cand;

    // Scan candidates in priority order; first requester wins.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = 0; k < NUM_FU; k++) begin
`ifdef CDB_ARB_FIXED_PRIO_EN
            cand = FU_IDX_W'(k);
`else
            cand = FU_IDX_W'((int'(ptr) + k) % NUM_FU);
`endif
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one holding register per FU, one grant per cycle into ex_ic_reg.
// Build option: CDB_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU   = FU_COUNT,
    parameter int FU_IDX_W = $clog2(NUM_FU)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       squash,
    input  logic        [NUM_FU-1:0]   fu_valid,
    input  EX_IC_PACKET [NUM_FU-1:0]   fu_packet,
    output logic        [NUM_FU-1:0]   fu_ready,
    output EX_IC_PACKET                ex_ic_reg,
    output logic        [FU_IDX_W-1:0] grant_idx
);

    logic        [NUM_FU-1:0]   hold_valid;
    EX_IC_PACKET [NUM_FU-1:0]   hold_pkt;
    logic        [FU_IDX_W-1:0] rr_ptr;
    logic        [NUM_FU-1:0]   gnt;
    logic        [FU_IDX_W-1:0] win_idx;
    logic                       win_any;
    logic        [NUM_FU-1:0]   accept;
    EX_IC_PACKET                win_pkt;

    cdb_arbiter_rr_picker #(
        .NUM_FU   (NUM_FU),
        .FU_IDX_W (FU_IDX_W)
    ) u_picker (
        .req (hold_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (win_idx),
        .any (win_any)
    );

    // An FU may hand over when its slot is empty or draining this cycle.
    assign fu_ready = {NUM_FU{!squash}} & (~hold_valid | gnt);
    assign accept   = fu_valid & fu_ready;

    // Winner packet, marked valid for the complete stage.
    always_comb begin
        win_pkt       = hold_pkt[win_idx];
        win_pkt.valid = 1'b1;
    end

    // Occupancy: a granted slot empties unless refilled in the same cycle.
    always_ff @(posedge clock) begin
        if (reset || squash) begin
            hold_valid <= '0;
        end else begin
            hold_valid <= accept | (hold_valid & ~gnt);
        end
    end

    // Payload capture; held data only changes on a new accept.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (accept[i]) begin
                hold_pkt[i] <= fu_packet[i];
            end
        end
    end

    // Register the winner; a squash discards this cycle's grant.
    always_ff @(posedge clock) begin
        if (reset) begin
            ex_ic_reg <= '0;
            grant_idx <= '0;
        end else if (squash) begin
            ex_ic_reg.valid <= 1'b0;
        end else if (win_any) begin
            ex_ic_reg <= win_pkt;
            grant_idx <= win_idx;
        end else begin
            ex_ic_reg.valid <= 1'b0;
        end
    end

`ifdef CDB_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    // Rotate priority to just past the last winner.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (!squash && win_any) begin
            rr_ptr <= (win_idx == FU_IDX_W'(NUM_FU - 1)) ? '0 : win_idx + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed scenarios plus random traffic
// checked against a queue-based model of the completion rules.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NF = FU_COUNT;
    localparam int W  = $clog2(NF);

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic                   squash = 1'b0;
    logic        [NF-1:0]   fu_valid = '0;
    EX_IC_PACKET [NF-1:0]   fu_packet = '0;
    logic        [NF-1:0]   fu_ready;
    EX_IC_PACKET            ex_ic_reg;
    logic        [W-1:0]    grant_idx;

    always #5 clock = ~clock;

    cdb_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .squash    (squash),
        .fu_valid  (fu_valid),
        .fu_packet (fu_packet),
        .fu_ready  (fu_ready),
        .ex_ic_reg (ex_ic_reg),
        .grant_idx (grant_idx)
    );

    typedef struct {
        EX_IC_PACKET pkt;
        int          g;
    } exp_t;

    exp_t        exp_q[$];
    bit          mh[NF];
    EX_IC_PACKET mp[NF];
    int          ptr = 0;
    int          checks = 0;
    int          failures = 0;
    logic [NF-1:0] last_acc = '0;

    // Model winner: first occupied slot scanning from ptr (or from 0).
    function automatic int pick();
        int s;
        for (int k = 0; k < NF; k++) begin
`ifdef CDB_ARB_FIXED_PRIO_EN
            s = k;
`else
            s = (ptr + k) % NF;
`endif
            if (mh[s]) return s;
        end
        return -1;
    endfunction

    function automatic EX_IC_PACKET rnd_pkt();
        EX_IC_PACKET p;
        p.valid       = 1'($urandom_range(1));
        p.dest_tag    = TAG_W'($urandom);
        p.rob_idx     = ROB_IDX_W'($urandom);
        p.result      = $urandom;
        p.rs2_value   = $urandom;
        p.take_branch = 1'($urandom_range(1));
        return p;
    endfunction

    function automatic EX_IC_PACKET mk(input int tag, input int rob);
        EX_IC_PACKET p;
        p          = rnd_pkt();
        p.dest_tag = TAG_W'(tag);
        p.rob_idx  = ROB_IDX_W'(rob);
        return p;
    endfunction

    task automatic do_cycle(input logic [NF-1:0] v,
                            input EX_IC_PACKET [NF-1:0] p,
                            input logic sq, input logic rst);
        logic [NF-1:0] er;
        int w;
        exp_t e;
        @(negedge clock);
        reset     = rst;
        squash    = sq;
        fu_valid  = v;
        fu_packet = p;
        #1;
        w = pick();
        for (int i = 0; i < NF; i++)
            er[i] = !sq && (!mh[i] || w == i);
        checks++;
        if (fu_ready !== er) begin
            failures++;
            $display("FAIL fu_ready got=%b exp=%b t=%0t", fu_ready, er, $time);
        end
        last_acc = v & er;
        if (rst) begin
            for (int i = 0; i < NF; i++) mh[i] = 1'b0;
            ptr = 0;
        end else if (sq) begin
            for (int i = 0; i < NF; i++) mh[i] = 1'b0;
        end else begin
            if (w >= 0) begin
                e.pkt       = mp[w];
                e.pkt.valid = 1'b1;
                e.g         = w;
                exp_q.push_back(e);
                mh[w] = 1'b0;
                ptr   = (w + 1) % NF;
            end
            for (int i = 0; i < NF; i++) begin
                if (last_acc[i]) begin
                    mh[i] = 1'b1;
                    mp[i] = p[i];
                end
            end
        end
    endtask

    task automatic idle(input int n);
        EX_IC_PACKET [NF-1:0] z;
        z = '0;
        repeat (n) do_cycle('0, z, 1'b0, 1'b0);
    endtask

    task automatic check_reset();
        @(posedge clock);
        #2;
        checks++;
        if (ex_ic_reg !== '0) begin
            failures++;
            $display("FAIL reset_ex_ic got=%h exp=0", ex_ic_reg);
        end
        checks++;
        if (grant_idx !== '0) begin
            failures++;
            $display("FAIL reset_grant_idx got=%0d exp=0", grant_idx);
        end
    endtask

    // Monitor: every cycle the output must match the scoreboard head.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            checks++;
            if (ex_ic_reg.valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_out got rob=%0d g=%0d exp none",
                             ex_ic_reg.rob_idx, grant_idx);
                end else begin
                    e = exp_q.pop_front();
                    if (ex_ic_reg !== e.pkt || grant_idx !== W'(e.g)) begin
                        failures++;
                        $display("FAIL out_pkt got=%h g=%0d exp=%h g=%0d",
                                 ex_ic_reg, grant_idx, e.pkt, e.g);
                    end
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                failures++;
                $display("FAIL missing_out got valid=%b exp rob=%0d g=%0d",
                         ex_ic_reg.valid, e.pkt.rob_idx, e.g);
            end
        end
    end

    initial begin : driver
        EX_IC_PACKET [NF-1:0] pv;
        logic [NF-1:0]        rv;
        logic                 prev_flush;
        logic                 sq;
        logic                 rs;

        pv = '0;
        do_cycle('0, pv, 1'b0, 1'b1);
        check_reset();

        // Single requester on FU2: output two cycles later.
        pv[2] = mk(7, 5);
        do_cycle(4'b0100, pv, 1'b0, 1'b0);
        idle(3);

        // All four from reset: grants 0,1,2,3.
        do_cycle('0, pv, 1'b0, 1'b1);
        check_reset();
        for (int i = 0; i < NF; i++) pv[i] = mk(i + 1, i + 10);
        do_cycle(4'b1111, pv, 1'b0, 1'b0);
        idle(5);

        // FU0 streaming while FU3 is held.
        pv[3] = mk(33, 3);
        pv[0] = mk(1, 0);
        do_cycle(4'b1001, pv, 1'b0, 1'b0);
        for (int c = 0; c < 8; c++) begin
            if (last_acc[0]) pv[0] = mk(c, c + 16);
            do_cycle(4'b0001, pv, 1'b0, 1'b0);
        end
        idle(4);

        // Back-to-back on FU1 alone.
        for (int r = 1; r <= 3; r++) begin
            pv[1] = mk(r + 20, r);
            do_cycle(4'b0010, pv, 1'b0, 1'b0);
        end
        idle(4);

        // Squash with FU0/FU2 held and output valid.
        pv[0] = mk(40, 8);
        pv[2] = mk(42, 9);
        do_cycle(4'b0101, pv, 1'b0, 1'b0);
        do_cycle('0, pv, 1'b0, 1'b0);
        pv[1] = mk(41, 11);
        do_cycle(4'b0010, pv, 1'b1, 1'b0);
        idle(4);

        // Reset with three entries held.
        for (int i = 0; i < NF; i++) pv[i] = mk(i + 50, i + 20);
        do_cycle(4'b0111, pv, 1'b0, 1'b0);
        do_cycle('0, pv, 1'b0, 1'b1);
        check_reset();
        do_cycle(4'b1111, pv, 1'b0, 1'b0);
        idle(5);

        // Random traffic; stalled FUs hold their offer stable.
        rv = '0;
        prev_flush = 1'b1;
        for (int c = 0; c < 400; c++) begin
            sq = ($urandom_range(19) == 0);
            rs = ($urandom_range(99) == 0);
            for (int i = 0; i < NF; i++) begin
                if (!(rv[i] && !last_acc[i] && !prev_flush)) begin
                    rv[i] = 1'($urandom_range(1));
                    pv[i] = rnd_pkt();
                end
            end
            do_cycle(rv, pv, sq, rs);
            prev_flush = sq | rs;
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
